// File: rtl/uop_debounce_pkg.sv
// Shared types and constants for the two-channel switch debouncer.
// Holds the per-channel FSM state encoding and the default debounce lengths
// for simulation and for the 50 MHz board.
package uop_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } db_state_t;

  // Short filter keeps simulation fast; the board value gives ~10 ms at 50 MHz.
  localparam int unsigned DbCyclesSim   = 4;
  localparam int unsigned DbCyclesBoard = 500000;

endpackage

// File: rtl/uop_debounce_ch.sv
// One debounce channel: two-flop synchroniser, stability FSM with counter,
// registered clean level and one-cycle rise/fall pulses.
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-high reset
//   sw_i    - raw, asynchronous, bouncing switch input
//   level_o - debounced level
//   rise_o  - one-cycle pulse coincident with level_o going 0 -> 1
//   fall_o  - one-cycle pulse coincident with level_o going 1 -> 0
module uop_debounce_ch
  import uop_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DbCyclesSim,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= STABLE_LO;
      count_q <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // count_d defaults to zero so every path that lands in a STABLE state clears it.
  always_comb begin
    state_d = state_q;
    count_d = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (sync2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = WAIT_HI;
            count_d = CntOne;
          end
        end
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          state_d = STABLE_LO;  // bounce: abandon candidate silently
        end else if (count_q == CntLast) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          count_d = count_q + CntOne;
        end
      end
      STABLE_HI: begin
        if (!sync2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = WAIT_LO;
            count_d = CntOne;
          end
        end
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = STABLE_HI;
        end else if (count_q == CntLast) begin
          state_d = STABLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          count_d = count_q + CntOne;
        end
      end
    endcase
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/uop_debounce2.sv
// Two independent debounced switch channels feeding a two-input gate block.
// Ports:
//   clk            - system clock, rising edge
//   reset          - asynchronous active-high reset
//   sw_a, sw_b     - raw asynchronous switch inputs
//   a, b           - debounced levels
//   a_rise, a_fall - one-cycle edge pulses for a
//   b_rise, b_fall - one-cycle edge pulses for b
module uop_debounce2
  import uop_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DbCyclesSim,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_a,
  input  logic sw_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  uop_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch_a (
    .clk    (clk),
    .reset  (reset),
    .sw_i   (sw_a),
    .level_o(a),
    .rise_o (a_rise),
    .fall_o (a_fall)
  );

  uop_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch_b (
    .clk    (clk),
    .reset  (reset),
    .sw_i   (sw_b),
    .level_o(b),
    .rise_o (b_rise),
    .fall_o (b_fall)
  );

endmodule

// File: tb/tb_uop_debounce2.sv
// Scoreboard bench for uop_debounce2. A window-based reference model predicts
// level changes from the history of captured raw values and queues the
// expected pulses; a monitor on the falling edge pops and compares.
module tb_uop_debounce2;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sw_a = 1'b0;
  logic sw_b = 1'b0;
  logic a, b, a_rise, a_fall, b_rise, b_fall;

  uop_debounce2 #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw_a  (sw_a),
    .sw_b  (sw_b),
    .a     (a),
    .b     (b),
    .a_rise(a_rise),
    .a_fall(a_fall),
    .b_rise(b_rise),
    .b_fall(b_fall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int ch;
    bit rise;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  bit  lev[2];
  bit  hist[2][$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cycle %0d: got {a,b,ar,af,br,bf}=%b, expected %b", name, cyc, act, req);
    end
  endtask

  // Reference model: the FSM sees the value captured two edges earlier, so at
  // edge k the output flips iff the D captures at edges k-D-1..k-2 all differ
  // from the current level.
  initial begin
    bit raw;
    bit all_diff;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        for (int ch = 0; ch < 2; ch++) begin
          hist[ch].delete();
          for (int i = 0; i < int'(D) + 2; i++) hist[ch].push_back(1'b0);
          lev[ch] = 1'b0;
        end
        exp_q.delete();
      end else begin
        for (int ch = 0; ch < 2; ch++) begin
          raw = (ch == 0) ? sw_a : sw_b;
          hist[ch].push_back(raw);
          all_diff = 1'b1;
          for (int i = 1; i <= int'(D); i++) if (hist[ch][i] == lev[ch]) all_diff = 1'b0;
          if (all_diff) begin
            lev[ch] = ~lev[ch];
            exp_q.push_back('{cyc: cyc, ch: ch, rise: lev[ch]});
          end
          void'(hist[ch].pop_front());
        end
      end
    end
  end

  // Monitor: compares levels and pulses every cycle against the model.
  initial begin
    ev_t          ev;
    logic [5:0]   req;
    #4;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        req = 6'b0;
      end else begin
        req = {lev[0], lev[1], 4'b0000};
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          ev = exp_q.pop_front();
          if (ev.cyc < cyc) begin
            n_err++;
            $display("FAIL stale_event cycle %0d: event for cycle %0d never matched", cyc, ev.cyc);
          end else if (ev.ch == 0) begin
            if (ev.rise) req[3] = 1'b1;
            else req[2] = 1'b1;
          end else begin
            if (ev.rise) req[1] = 1'b1;
            else req[0] = 1'b1;
          end
        end
      end
      check("outputs", {a, b, a_rise, a_fall, b_rise, b_fall}, req);
    end
  end

  task automatic drive(input bit va, input bit vb, input int n);
    sw_a = va;
    sw_b = vb;
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  initial begin
    int bits[6];
    bit ra, rb;
    bits = '{1, 0, 1, 1, 0, 1};
    // Asynchronous reset with switches high: outputs clear before any clock edge.
    #1 sw_a = 1'b1;
    sw_b = 1'b1;
    #1 reset = 1'b1;
    #1 check("reset_async", {a, b, a_rise, a_fall, b_rise, b_fall}, 6'b0);
    @(posedge clk);
    #3;
    drive(1, 1, 3);
    reset = 1'b0;
    // Held-high switches re-qualify after reset: one rise each.
    drive(1, 1, 12);
    drive(0, 0, 12);
    // Clean step on A only.
    drive(1, 0, 10);
    drive(0, 0, 10);
    // Threshold: 3-cycle pulse rejected, 4-cycle pulse accepted.
    drive(1, 0, 3);
    drive(0, 0, 10);
    drive(1, 0, 4);
    drive(0, 0, 12);
    // Bounce on B.
    foreach (bits[i]) drive(0, bits[i][0], 1);
    drive(0, 1, 12);
    drive(0, 0, 12);
    // Simultaneous toggles.
    drive(1, 1, 10);
    drive(0, 0, 10);
    // Reset while A is being timed (count reaches 2), then release with A held.
    drive(1, 0, 4);
    reset = 1'b1;
    #1 check("reset_mid_wait", {a, b, a_rise, a_fall, b_rise, b_fall}, 6'b0);
    #2;
    drive(1, 0, 3);
    reset = 1'b0;
    drive(1, 0, 12);
    drive(0, 0, 12);
    // Randomised bouncing on both channels.
    ra = 1'b0;
    rb = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) ra = ~ra;
      if ($urandom_range(0, 2) == 0) rb = ~rb;
      drive(ra, rb, int'($urandom_range(1, 7)));
    end
    drive(0, 0, 12);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
